// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch controller between the core's rom_addr
// port and a variable-latency req/ack instruction memory.
//
// Handshake: imem_req stays high for every cycle the controller is in REQ
// with imem_addr held stable. A cycle with imem_req=1 and imem_ack=1
// completes the read and imem_rdata is captured on that edge. imem_ack and
// imem_rdata are ignored in every other state. rom_rdy is a one-cycle pulse
// marking a new instruction on rom_rdata.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a read after TIMEOUT
// REQ cycles without an ack. The aborted fetch returns NOP_INSTR and sets
// fetch_err.
module imem_fetch_ctrl #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_rdata,
    output logic              rom_rdy,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              fetch_err,
    output logic [1:0]        state_dbg,
    output logic [7:0]        wait_cnt_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        REQ    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A TIMEOUT outside 1..255 cannot be reached by the 8-bit wait counter.
    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
            $error("imem_fetch_ctrl: TIMEOUT must be in 1..255");
        end
    endgenerate

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
`endif

    state_t            state;
    state_t            state_next;
    logic [31:0]       rdata_next;
    logic [ADDR_W-1:0] addr_next;
    logic              err_next;
    logic [7:0]        wait_cnt;
    logic [7:0]        cnt_next;

    // Next-state and datapath update: every register holds unless its state says otherwise.
    always_comb begin
        state_next = state;
        rdata_next = rom_rdata;
        addr_next  = imem_addr;
        err_next   = fetch_err;
        cnt_next   = wait_cnt;
        case (state)
            IDLE: begin
                state_next = LAUNCH;
            end
            LAUNCH: begin
                // The core moved its PC on the DONE edge, so rom_addr is the new fetch address.
                addr_next = rom_addr;
                if (rom_addr[1:0] != 2'b00) begin
                    state_next = DONE;
                    rdata_next = NOP_INSTR;
                    err_next   = 1'b1;
                end else begin
                    state_next = REQ;
                    cnt_next   = 8'd0;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    state_next = DONE;
                    rdata_next = imem_rdata;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_LAST) begin
                    state_next = DONE;
                    rdata_next = NOP_INSTR;
                    err_next   = 1'b1;
                end
`endif
                else if (wait_cnt != 8'hFF) begin
                    cnt_next = wait_cnt + 8'd1;
                end
            end
            DONE: begin
                state_next = LAUNCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, captured instruction, memory address, sticky error and wait counter.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            rom_rdata <= NOP_INSTR;
            rom_rdy   <= 1'b0;
            imem_addr <= '0;
            fetch_err <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            state     <= state_next;
            rom_rdata <= rdata_next;
            rom_rdy   <= (state_next == DONE);
            imem_addr <= addr_next;
            fetch_err <= err_next;
            wait_cnt  <= cnt_next;
        end
    end

    // Request follows the state directly so an asynchronous reset drops it at once.
    always_comb begin
        imem_req     = (state == REQ);
        state_dbg    = state;
        wait_cnt_dbg = wait_cnt;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a randomized core PC driver, a
// variable-latency memory responder and a scoreboard monitor.
module tb_imem_fetch_ctrl;
  localparam int          ADDR_W  = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic [31:0] rom_rdata;
  logic        rom_rdy;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        fetch_err;
  logic [1:0]  state_dbg;
  logic [7:0]  wait_cnt_dbg;

  imem_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .NOP_INSTR(NOP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .rom_rdy     (rom_rdy),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg),
    .wait_cnt_dbg(wait_cnt_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];       // expected rom_rdata per fetch
  logic        exp_err_q[$];   // expected fetch_err at the rdy pulse
  logic [31:0] exp_addr_q[$];  // expected imem_addr at the rdy pulse
  int          exp_req_q[$];   // expected number of imem_req cycles
  int          wait_q[$];      // ack delay the memory applies per request

  logic        err_model = 1'b0;
  logic [31:0] held_model = NOP;
  int          done_count = 0;
  logic        phase_start = 1'b0;
  int          phase_num = 0;
  int          dir_idx = 0;
  logic [31:0] dir_a[2] = '{32'h4, 32'h8};
  int          dir_w[2] = '{4, 0};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return $urandom_range(0, 2);
    if (r < 17) return $urandom_range(3, 6);
    if (r == 17) return 15;
    if (r == 18) return 16;
    return 20;
  endfunction

  // Record what one fetch of address a with ack delay w must produce.
  task automatic push_fetch(input logic [31:0] a, input int w);
    rom_addr = a;
    exp_addr_q.push_back(a);
    if (a[1:0] != 2'b00) begin
      err_model = 1'b1;
      exp_q.push_back(NOP);
      exp_req_q.push_back(0);
    end else begin
      wait_q.push_back(w);
`ifdef FETCH_TIMEOUT_EN
      if (w >= TIMEOUT) begin
        err_model = 1'b1;
        exp_q.push_back(NOP);
        exp_req_q.push_back(TIMEOUT);
      end else
`endif
      begin
        exp_q.push_back(mem_word(a));
        exp_req_q.push_back(w + 1);
      end
    end
    exp_err_q.push_back(err_model);
  endtask

  // ---------------- driver: core PC ----------------
  always @(negedge clk) begin
    logic [31:0] a;
    int r;
    if (!sys_rst_n) begin
      if (phase_start) begin
        exp_q.delete(); exp_err_q.delete(); exp_addr_q.delete();
        exp_req_q.delete(); wait_q.delete();
        err_model = 1'b0;
        if (phase_num == 0) push_fetch(32'h0, 0);
        else push_fetch($urandom & 32'h0000_FFFC, pick_wait());
        phase_start = 1'b0;
      end
    end else if (rom_rdy) begin
      if (phase_num == 0 && dir_idx < 2) begin
        push_fetch(dir_a[dir_idx], dir_w[dir_idx]);
        dir_idx++;
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0) a = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
        else if (r == 1) a = $urandom & 32'h0000_FFFC;
        else a = (rom_addr & 32'hFFFF_FFFC) + 32'h4;
        push_fetch(a, pick_wait());
      end
    end
  end

  // ---------------- driver: instruction memory ----------------
  always @(negedge clk) begin
    static logic        busy = 1'b0;
    static int          cnt = 0;
    static int          cur_w = 0;
    static logic [31:0] req_addr = 32'h0;
    if (!sys_rst_n) begin
      busy = 1'b0;
      imem_ack = 1'b1;            // stale ack that must be ignored after release
      imem_rdata = $urandom;
    end else if (imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        cnt = 0;
        req_addr = imem_addr;
        if (wait_q.size() > 0) cur_w = wait_q.pop_front();
        else begin
          check("unexpected_req", imem_addr, 32'hFFFF_FFFF);
          cur_w = 0;
        end
      end else begin
        check("addr_stable", imem_addr, req_addr);
      end
      if (cnt == cur_w) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(req_addr);
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
      end
      cnt++;
    end else begin
      busy = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    static int   since = 0;
    static int   req_seen = 0;
    static logic prev_rdy = 1'b0;
    if (!sys_rst_n) begin
      since = 0;
      req_seen = 0;
      prev_rdy = 1'b0;
      held_model = NOP;
    end else begin
      if (rom_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", rom_rdata, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e_data;
          logic        e_err;
          logic [31:0] e_addr;
          int          e_req;
          e_data = exp_q.pop_front();
          e_err  = exp_err_q.pop_front();
          e_addr = exp_addr_q.pop_front();
          e_req  = exp_req_q.pop_front();
          check("rom_rdata", rom_rdata, e_data);
          check("fetch_err", 32'(fetch_err), 32'(e_err));
          check("imem_addr", imem_addr, e_addr);
          check("req_cycles", 32'(req_seen), 32'(e_req));
          check("fetch_period", 32'(since), 32'(e_req + 1));
          held_model = e_data;
          done_count++;
        end
        check("rdy_without_req", 32'(imem_req), 32'h0);
        check("rdy_single_pulse", 32'(prev_rdy), 32'h0);
        since = 0;
        req_seen = 0;
      end else begin
        since++;
        if (imem_req) req_seen++;
        check("rdata_hold", rom_rdata, held_model);
      end
      prev_rdy = rom_rdy;
    end
  end

  // ---------------- reset control and run sequence ----------------
  task automatic wait_fetches(input int n);
    int target;
    target = done_count + n;
    for (int c = 0; c < n * 40; c++) begin
      @(negedge clk);
      if (done_count >= target) break;
    end
    if (done_count < target) check("fetch_budget", 32'(done_count), 32'(target));
  endtask

  initial begin
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rom_rdata", rom_rdata, NOP);
    check("rst_rom_rdy", 32'(rom_rdy), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_fetch_err", 32'(fetch_err), 32'h0);
    check("rst_wait_cnt", 32'(wait_cnt_dbg), 32'h0);

    phase_num = 0;
    phase_start = 1'b1;
    @(negedge clk);
    #2 sys_rst_n = 1'b1;
    wait_fetches(150);

    // Reset in the middle of a memory read.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (imem_req) break;
    end
    check("reached_req", 32'(imem_req), 32'h1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'h0);
    check("async_rst_rdata", rom_rdata, NOP);
    check("async_rst_err", 32'(fetch_err), 32'h0);
    check("async_rst_rdy", 32'(rom_rdy), 32'h0);

    phase_num = 1;
    phase_start = 1'b1;
    repeat (2) @(negedge clk);
    #2 sys_rst_n = 1'b1;
    wait_fetches(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch controller sitting directly upstream of the single-cycle core's instruction port.
- Takes the core's rom_addr, runs a req/ack read on an external instruction memory with variable latency, and returns rom_rdata.
- Pulses rom_rdy for one cycle per fetched instruction; the core's PC and register-write timing key off that pulse.
- Holds the instruction stable between fetches so the core's combinational decode stays valid.

Parameters:
- ADDR_W, 32, width of rom_addr and imem_addr.
- NOP_INSTR, 32'h00000013, value driven on rom_rdata after reset, on misalign and on timeout (addi x0,x0,0).
- TIMEOUT, 16, max REQ cycles before abort; used only when FETCH_TIMEOUT_EN is defined; valid range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- rom_addr  in  ADDR_W  fetch address from the core's PC.
- rom_rdata  out  32  registered instruction to the core.
- rom_rdy  out  1  one-cycle pulse: new instruction valid on rom_rdata this cycle.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  registered word address to instruction memory.
- imem_rdata  in  32  read data, sampled only when imem_ack=1.
- imem_ack  in  1  memory completion, may assert in the first REQ cycle.
- fetch_err  out  1  sticky error flag (misalign; timeout when enabled).

Behaviour:
- Clock and reset: single clock clk; reset sys_rst_n asynchronous, active-low.
- Reset values: state=IDLE, rom_rdata=NOP_INSTR, rom_rdy=0, imem_req=0, imem_addr=0, fetch_err=0, wait counter=0.
- Reset mid-fetch: imem_req drops immediately (asynchronous). Any in-flight ack after reset release is ignored because state≠REQ.
- FSM states: IDLE, LAUNCH, REQ, DONE.
- IDLE -> LAUNCH: unconditional on the first clock after reset release.
- LAUNCH (1 cycle): latch rom_addr into imem_addr at the cycle's end.
  - If rom_addr[1:0]≠0: next state DONE, rom_rdata<=NOP_INSTR, fetch_err<=1, no request issued.
  - Otherwise: next state REQ.
- REQ: imem_req=1 (combinational from state); imem_addr held.
  - imem_ack=1: rom_rdata<=imem_rdata, next state DONE.
  - imem_ack=0: stay in REQ, wait counter increments.
- DONE (1 cycle): rom_rdy=1 (registered, asserted exactly while in DONE); next state LAUNCH.
  - The core updates its PC on this edge, so LAUNCH samples the new rom_addr.
- Throughput: minimum 3 cycles per instruction (LAUNCH, REQ with immediate ack, DONE); each extra REQ wait cycle adds 1.
- Data hold: rom_rdata changes only on the clock edge leaving REQ (or the misaligned LAUNCH). It is stable through DONE and the following LAUNCH/REQ.
- imem_rdata is ignored whenever imem_ack=0 or state≠REQ. imem_ack outside REQ has no effect.
- rom_rdy is never high for two consecutive cycles and never high while imem_req=1.
- fetch_err clears only on reset.
- Wait counter: 8 bits, cleared on entry to REQ, saturates at 255.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: if the wait counter reaches TIMEOUT-1 in REQ with imem_ack=0, the next edge forces DONE, rom_rdata<=NOP_INSTR and fetch_err<=1, and imem_req drops. An ack arriving in that same cycle takes priority, giving a normal capture with no error.
- Not defined: REQ waits indefinitely; no timeout logic is synthesised; the counter exists only if needed for debug and never alters the FSM.

Test Plan:
- Reset release with rom_addr=0x00000000, memory acks in the first REQ cycle returning 0x00500093 -> imem_req high in cycle 2, rom_rdy pulse in cycle 3, rom_rdata=0x00500093, fetch_err=0.
- Ack delayed 4 REQ cycles for rom_addr=0x00000004, data 0x00A00113 -> imem_req high 5 cycles, imem_addr=0x00000004 stable throughout, single rom_rdy pulse after the ack edge, rom_rdata=0x00A00113 held until the next capture.
- Core sequence 0x0,0x4,0x8 via the rom_rdy-driven PC, with zero-wait memory -> rom_rdy every 3rd cycle, imem_addr 0x0/0x4/0x8 in order, no double pulses.
- rom_addr=0x00000006 -> no imem_req, rom_rdy pulse with rom_rdata=0x00000013, fetch_err=1 and stays 1.
- Assert sys_rst_n=0 asynchronously during REQ -> imem_req=0 and rom_rdata=0x00000013 before the next edge; a late imem_ack after release is ignored and a fresh LAUNCH follows.
- With FETCH_TIMEOUT_EN, TIMEOUT=16, no ack -> exactly 16 REQ cycles, then rom_rdy with rom_rdata=0x00000013 and fetch_err=1. With ack in the 16th cycle instead -> data captured, fetch_err=0.
